spi_slave: RTL

Byte-oriented SPI responder that forms the far end of the team's SPI master link (CPOL = 0, MOSI driven before the first rising SCLK edge, both sides sample on rising SCLK and shift on falling SCLK). It oversamples SCLK, MOSI and SS_N in the system `clk` domain and hands received words to local logic through a valid/ack interface. It returns a software-loaded word, or a default fill value, on MISO. Multi-word frames are supported while SS_N stays low.

---
 rtl/spi_slave.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// spi_slave: byte-oriented SPI responder (CPOL = 0, sample on rising SCLK,
// shift on falling SCLK). SCLK, SS_N and MOSI are oversampled in the clk
// domain. Received words go to local logic through a valid/ack pair, and the
// transmit word comes from a single-entry holding buffer. When that buffer is
// empty, TX_DEFAULT is sent instead.
//
// Optional feature: define SPI_SLAVE_OVR_EN to enable the sticky overrun flag.
// When it is undefined, ovr is tied to 0 and an overwrite of rx_data is silent.
//
// Ports:
//   clk      in   system clock (rising edge)
//   rst      in   synchronous reset, active low
//   sclk     in   SPI clock from the master (asynchronous)
//   ss_n     in   slave select, active low (asynchronous)
//   mosi     in   serial data from the master
//   miso     out  serial data to the master (MSB of the TX shift register)
//   miso_oe  out  output enable for an external tristate, high while selected
//   tx_wr    in   one-cycle strobe that writes tx_din into the holding buffer
//   tx_din   in   word to send
//   tx_full  out  holding buffer holds an unsent word
//   rx_data  out  last completed received word
//   rx_valid out  rx_data is new and not yet acknowledged
//   rx_ack   in   consumer acknowledge, clears rx_valid
//   ovr      out  sticky overrun flag
module spi_slave #(
  parameter int                DWIDTH     = 8,
  parameter logic [DWIDTH-1:0] TX_DEFAULT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              tx_wr,
  input  logic [DWIDTH-1:0] tx_din,
  output logic              tx_full,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              ovr
);

  localparam int CNT_W = $clog2(DWIDTH);

  typedef enum logic [1:0] {DISARMED, IDLE, ACTIVE} state_t;

  // Returns the word to place in the TX shift register at a word boundary.
  function automatic logic [DWIDTH-1:0] tx_next_word(input logic full,
                                                     input logic [DWIDTH-1:0] buf_w);
    return full ? buf_w : TX_DEFAULT;
  endfunction

  logic              sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic              ss_s1_q, ss_s2_q;
  logic              mosi_s1_q, mosi_s2_q;
  logic [1:0]        sync_ok_q;
  state_t            state_q, state_d;
  logic [DWIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DWIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic [DWIDTH-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rise, fall, tx_load, word_done;

  assign rise = sclk_s2_q & ~sclk_s3_q;
  assign fall = ~sclk_s2_q & sclk_s3_q;

  // Input synchronizers. sync_ok_q marks when the synchronizer outputs are
  // real pin samples rather than reset values. Without it, the ss_n reset
  // value of 1 would arm the slave in the middle of a frame that was
  // already running when reset was released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      sync_ok_q <= 2'b00;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ss_s1_q   <= ss_n;
      ss_s2_q   <= ss_s1_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      sync_ok_q <= {sync_ok_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DISARMED;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    tx_load    = 1'b0;
    word_done  = 1'b0;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_valid_d = rx_valid_q;

    case (state_q)
      DISARMED: begin
        if (sync_ok_q[1] && ss_s2_q) state_d = IDLE;
      end
      IDLE: begin
        if (!ss_s2_q) begin
          state_d   = ACTIVE;
          tx_load   = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (ss_s2_q) begin
          // Deselect drops the partial word and any TX word already loaded.
          state_d = IDLE;
        end else if (rise) begin
          rx_sr_d = {rx_sr_q[DWIDTH-2:0], mosi_s2_q};
          if (bit_cnt_q == CNT_W'(DWIDTH - 1)) begin
            rx_data_d = {rx_sr_q[DWIDTH-2:0], mosi_s2_q};
            word_done = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (fall) begin
          // A fall while bit_cnt is 0 follows the last bit of a word, so the
          // next word is loaded here instead of shifting.
          if (bit_cnt_q == '0) tx_load = 1'b1;
          else                 tx_sr_d = {tx_sr_q[DWIDTH-2:0], 1'b0};
        end
      end
      default: state_d = DISARMED;
    endcase

    // The load takes the old buffer contents. A concurrent tx_wr then
    // refills the buffer and keeps it marked full.
    if (tx_load) begin
      tx_sr_d   = tx_next_word(tx_full_q, tx_buf_q);
      tx_full_d = 1'b0;
    end
    if (tx_wr) begin
      tx_buf_d  = tx_din;
      tx_full_d = 1'b1;
    end

    if (word_done)   rx_valid_d = 1'b1;
    else if (rx_ack) rx_valid_d = 1'b0;
  end

`ifdef SPI_SLAVE_OVR_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (word_done && rx_valid_q && !rx_ack) ovr_d = 1'b1;
    else if (rx_ack && !word_done)          ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) ovr_q <= 1'b0;
    else      ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  assign miso     = tx_sr_q[DWIDTH-1];
  assign miso_oe  = (state_q == ACTIVE);
  assign tx_full  = tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
